// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: state encoding,
// BCD digit constants and the iteration counter width.
package bcd_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int ADJ_THRESHOLD = 8;
    localparam int ADJ_VALUE     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } bcd_state_e;

    // Wide enough to hold the full shift count 4*digits.
    function automatic int cnt_width(input int digits);
        return $clog2(BCD_DIGIT_W * digits + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD nibble of the reverse double-dabble: subtracts 3 from a nibble of
// 8 or more, and flags a nibble that is not a legal decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_adj,
    output logic       o_gt9
);

    // Nibble correction and illegal-digit flag
    always_comb begin
        if (i_nib >= 4'(ADJ_THRESHOLD)) begin
            o_adj = i_nib - 4'(ADJ_VALUE);
        end else begin
            o_adj = i_nib;
        end
        o_gt9 = (i_nib > 4'(BCD_MAX_DIGIT));
    end

endmodule

// File: rtl/bcd_to_decimal.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with a
// start/busy/done handshake; the result saturates at 2^W-1.
module bcd_to_decimal
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                        busy,
    output logic                        done,
    output logic [W-1:0]                decimal,
    output logic                        overflow,
    output logic                        invalid
);

    localparam int BW    = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(DIGITS);

    bcd_state_e        r_state, w_state_nxt;
    logic [2*BW-1:0]   r_sr, w_sr_nxt, w_sr_shift, w_sr_adj;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [W-1:0]      r_decimal, w_decimal_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              r_invalid, w_invalid_nxt;

    logic [DIGITS-1:0] w_gt9;
    logic [DIGITS-1:0] w_unused_gt9;
    logic [BW-1:0]     w_unused_adj;
    logic [BW-1:0]     w_bin;
    logic [BW+W-1:0]   w_bin_ext;
    logic              w_sat_ovf;
    logic [W-1:0]      w_sat_val;

    assign w_sr_shift = {1'b0, r_sr[2*BW-1:1]};
    assign w_sr_adj[BW-1:0] = w_sr_shift[BW-1:0];

    // Upper half holds the BCD digits: adjust after the shift, and before the
    // first shift the same digits are screened for illegal values.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adj (
            .i_nib (w_sr_shift[BW + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_adj (w_sr_adj[BW + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_gt9 (w_unused_gt9[g])
        );
        bcd_digit_adjust u_chk (
            .i_nib (r_sr[BW + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_adj (w_unused_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_gt9 (w_gt9[g])
        );
    end

    assign w_bin     = r_sr[BW-1:0];
    assign w_bin_ext = {{W{1'b0}}, w_bin};
    assign w_sat_ovf = |w_bin_ext[BW+W-1:W];
    assign w_sat_val = w_sat_ovf ? {W{1'b1}} : w_bin_ext[W-1:0];

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_decimal_nxt  = r_decimal;
        w_overflow_nxt = r_overflow;
        w_invalid_nxt  = r_invalid;
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    w_sr_nxt    = {bcd, {BW{1'b0}}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if ((r_cnt == {CNT_W{1'b0}}) && (|w_gt9)) begin
                    w_state_nxt    = ST_FINISH;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_decimal_nxt  = {W{1'b0}};
                    w_overflow_nxt = 1'b0;
                    w_invalid_nxt  = 1'b1;
                end else if (r_cnt == CNT_W'(BW)) begin
                    w_state_nxt    = ST_FINISH;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_decimal_nxt  = w_sat_val;
                    w_overflow_nxt = w_sat_ovf;
                    w_invalid_nxt  = 1'b0;
                end else begin
                    w_sr_nxt  = w_sr_adj;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sr       <= {(2*BW){1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_decimal  <= {W{1'b0}};
            r_overflow <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_decimal  <= w_decimal_nxt;
            r_overflow <= w_overflow_nxt;
            r_invalid  <= w_invalid_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign decimal  = r_decimal;
    assign overflow = r_overflow;
    assign invalid  = r_invalid;

endmodule
